// File: rtl/example_mul_pkg.sv
// example_mul_pkg: shared constants and helpers for the multi-lane multiplier.
// Optional feature macro: MUL_SAT_EN (narrowing saturates instead of wrapping).
package example_mul_pkg;

  // Default widths and depths for the multiplier block
  localparam int DEF_A_W    = 14;
  localparam int DEF_B_W    = 9;
  localparam int DEF_OUT_W  = 21;
  localparam int DEF_LANES  = 4;
  localparam int DEF_STAGES = 3;
  localparam int DEF_SHIFT  = 0;

  // Working width for the shift/narrow step; products and outputs must fit in it
  localparam int CALC_W = 64;

  // Bit offset of a lane inside a packed multi-lane bus
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Arithmetic right shift of a sign-extended product, then narrowing to out_w.
  // Wrap build: the caller keeps the low out_w bits, which is two's-complement
  // wrap (or sign-extension when out_w exceeds the shifted width).
  // Saturating build: clamp to the signed out_w range before the caller slices.
  function automatic logic signed [CALC_W-1:0] mul_narrow(
    input logic signed [CALC_W-1:0] full,
    input int                       shift,
    input int                       out_w
  );
    logic signed [CALC_W-1:0] sh;
`ifdef MUL_SAT_EN
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
`endif
    sh = full >>> shift;
`ifdef MUL_SAT_EN
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sh > hi) begin
      sh = hi;
    end else if (sh < lo) begin
      sh = lo;
    end
`endif
    return sh;
  endfunction

endpackage

// File: rtl/example_mul_pipe_slot.sv
// example_mul_pipe_slot: one pipeline slot (valid bit + data) with
// hold/advance flow control. The slot refills whenever it is empty or its
// contents move on this cycle; otherwise it holds data stable.
module example_mul_pipe_slot
  import example_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  input  logic [W-1:0] up_dat,
  input  logic         down_rdy,
  output logic         rdy,
  output logic         vld,
  output logic [W-1:0] dat
);

  // Empty slots always accept; full slots accept only when draining this cycle
  assign rdy = !vld || down_rdy;

  // Occupancy: take the upstream valid whenever the slot is free to load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (rdy) begin
      vld <= up_vld;
    end
  end

  // Payload: load only real beats so a holding or emptying slot keeps its value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat <= '0;
    end else if (rdy && up_vld) begin
      dat <= up_dat;
    end
  end

endmodule

// File: rtl/example_mul_pipe_lanes.sv
// example_mul_pipe_lanes: LANES independent signed products per beat through a
// STAGES-deep stallable valid/ready pipeline, with arithmetic right shift by
// SHIFT and narrowing to OUT_W. Optional macro MUL_SAT_EN selects saturating
// narrowing; without it results wrap. Requires A_W+B_W < 64 and OUT_W < 64.
module example_mul_pipe_lanes
  import example_mul_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int LANES  = DEF_LANES,
  parameter int STAGES = DEF_STAGES,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_p
);

  localparam int P_W = A_W + B_W;
  localparam int D_W = LANES * OUT_W;

  logic [D_W-1:0] prod_p0;

  // ---- stage 0 input: per-lane product, shift and narrow (combinational) ----
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [A_W-1:0]    a_l;
    logic signed [B_W-1:0]    b_l;
    logic signed [P_W-1:0]    full;
    logic signed [CALC_W-1:0] full_ext;
    logic signed [CALC_W-1:0] nar;
    logic                     nar_unused;

    assign a_l      = in_a[lane_lsb(i, A_W) +: A_W];
    assign b_l      = in_b[lane_lsb(i, B_W) +: B_W];
    assign full     = a_l * b_l;
    assign full_ext = {{(CALC_W-P_W){full[P_W-1]}}, full};
    assign nar      = mul_narrow(full_ext, SHIFT, OUT_W);
    assign prod_p0[lane_lsb(i, OUT_W) +: OUT_W] = nar[OUT_W-1:0];
    assign nar_unused = ^nar[CALC_W-1:OUT_W];
  end

  // ---- slot chain: slot 0 captures products, later slots copy forward ----
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic           up_vld;
    logic [D_W-1:0] up_dat;
    logic           down_rdy;
    logic           rdy;
    logic           vld;
    logic [D_W-1:0] dat;

    if (k == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_dat = prod_p0;
    end else begin : g_body
      assign up_vld = g_slot[k-1].vld;
      assign up_dat = g_slot[k-1].dat;
    end

    if (k == STAGES - 1) begin : g_tail
      assign down_rdy = out_ready;
    end else begin : g_next
      assign down_rdy = g_slot[k+1].rdy;
    end

    example_mul_pipe_slot #(
      .W(D_W)
    ) u_slot (
      .clk      (ap_clk),
      .rst      (ap_rst),
      .up_vld   (up_vld),
      .up_dat   (up_dat),
      .down_rdy (down_rdy),
      .rdy      (rdy),
      .vld      (vld),
      .dat      (dat)
    );
  end

  // ---- output: straight from the last slot register ----
  assign out_valid = g_slot[STAGES-1].vld;
  assign out_p     = g_slot[STAGES-1].dat;

  // Ready is held low while reset is asserted so nothing is offered as accepted
  assign in_ready  = g_slot[0].rdy && !ap_rst;

endmodule

// File: tb/tb_example_mul_pipe_lanes.sv
// Self-checking bench for example_mul_pipe_lanes: directed scenarios plus a
// randomized handshake run scored against an arithmetic reference model.
module tb_example_mul_pipe_lanes;

  localparam int A_W    = 14;
  localparam int B_W    = 9;
  localparam int OUT_W  = 21;
  localparam int LANES  = 4;
  localparam int STAGES = 3;
  localparam int AV_W   = LANES * A_W;
  localparam int BV_W   = LANES * B_W;
  localparam int D_W    = LANES * OUT_W;

  logic            clk = 1'b0;
  logic            ap_rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [AV_W-1:0] in_a = '0;
  logic [BV_W-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [D_W-1:0]  out_p;

  logic            s4_valid = 1'b0;
  logic            s4_in_ready;
  logic [AV_W-1:0] s4_a = '0;
  logic [BV_W-1:0] s4_b = '0;
  logic            s4_out_valid;
  logic            s4_ordy = 1'b1;
  logic [D_W-1:0]  s4_p;

  int checks   = 0;
  int failures = 0;
  logic [D_W-1:0] sb[$];

  always #5 clk = ~clk;

  example_mul_pipe_lanes dut (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p)
  );

  example_mul_pipe_lanes #(.SHIFT(4)) dut_s4 (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(s4_valid), .in_ready(s4_in_ready),
    .in_a(s4_a), .in_b(s4_b), .out_valid(s4_out_valid), .out_ready(s4_ordy),
    .out_p(s4_p)
  );

  // Reference: exact product, floor division by 2^sh, then wrap or clamp
  function automatic longint ref_lane(input longint a, input longint b, input int sh);
    longint full, d, q, m, r;
    full = a * b;
    d = longint'(1) << sh;
    q = full / d;
    if ((full % d) != 0 && full < 0) q = q - 1;
`ifdef MUL_SAT_EN
    m = longint'(1) << (OUT_W - 1);
    if (q > m - 1) return m - 1;
    if (q < -m) return -m;
    return q;
`else
    m = longint'(1) << OUT_W;
    r = q % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
`endif
  endfunction

  function automatic logic [D_W-1:0] exp_vec(input logic [AV_W-1:0] av,
                                             input logic [BV_W-1:0] bv, input int sh);
    logic [D_W-1:0] e;
    logic signed [A_W-1:0] ta;
    logic signed [B_W-1:0] tb;
    longint v;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      ta = av[i*A_W +: A_W];
      tb = bv[i*B_W +: B_W];
      v = ref_lane(longint'(ta), longint'(tb), sh);
      e[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return e;
  endfunction

  // One cycle: drive at negedge, sample 1ns later; handshakes complete at the next posedge
  task automatic step(input logic iv, input logic [AV_W-1:0] a, input logic [BV_W-1:0] b,
                      input logic ordy, output logic acc, output logic dlv,
                      output logic [D_W-1:0] p);
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    dlv = out_valid && ordy;
    p   = out_p;
    if (acc) sb.push_back(exp_vec(a, b, 0));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (out_p !== '0) begin failures++; $display("FAIL rst_out_p got=%h want=0", out_p); end
    @(negedge clk);
    ap_rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic acc, dlv;
    logic [D_W-1:0] p, e, q;
    logic [AV_W-1:0] a;
    logic [BV_W-1:0] b;
    logic signed [OUT_W-1:0] l0;
    a = '0; b = '0;
    a[A_W-1:0] = 14'sd100;
    b[B_W-1:0] = -9'sd3;
    l0 = -21'sd300;
    e = '0; e[OUT_W-1:0] = l0;
    step(1'b1, a, b, 1'b1, acc, dlv, p);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b want=1", acc); end
    for (int j = 1; j <= STAGES; j++) begin
      step(1'b0, '0, '0, 1'b1, acc, dlv, p);
      checks++;
      if (dlv !== (j == STAGES)) begin
        failures++; $display("FAIL basic_latency cyc=%0d out_valid=%b want=%b", j, dlv, (j == STAGES));
      end
      if (dlv) begin
        q = sb.pop_front();
        checks++; if (p !== e) begin failures++; $display("FAIL basic_value got=%h want=%h", p, e); end
        checks++; if (p !== q) begin failures++; $display("FAIL basic_model got=%h want=%h", p, q); end
      end
    end
  endtask

  task automatic test_shift();
    logic [D_W-1:0] e;
    logic signed [OUT_W-1:0] l0, l1;
    l0 = 21'sd187;
    l1 = -21'sd188;
    e = '0; e[OUT_W-1:0] = l0; e[OUT_W +: OUT_W] = l1;
    @(negedge clk);
    s4_valid = 1'b1; s4_a = '0; s4_b = '0;
    s4_a[A_W-1:0] = 14'sd1000;   s4_b[B_W-1:0] = 9'sd3;
    s4_a[A_W +: A_W] = -14'sd1000; s4_b[B_W +: B_W] = 9'sd3;
    #1;
    checks++; if (s4_in_ready !== 1'b1) begin failures++; $display("FAIL shift_accept got=%b want=1", s4_in_ready); end
    @(negedge clk);
    s4_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s4_out_valid !== 1'b1) begin failures++; $display("FAIL shift_valid got=%b want=1", s4_out_valid); end
    checks++; if (s4_p !== e) begin failures++; $display("FAIL shift_value got=%h want=%h", s4_p, e); end
    checks++; if (s4_p !== exp_vec(s4_a, s4_b, 4)) begin failures++; $display("FAIL shift_model got=%h want=%h", s4_p, exp_vec(s4_a, s4_b, 4)); end
  endtask

  task automatic test_narrow();
    logic acc, dlv;
    logic [D_W-1:0] p, q;
    logic [AV_W-1:0] a;
    logic [BV_W-1:0] b;
    logic signed [OUT_W-1:0] want [2];
    int n;
`ifdef MUL_SAT_EN
    want[0] = 21'sd1048575;  want[1] = -21'sd1048576;
`else
    want[0] = 21'sd0;        want[1] = 21'sd8192;
`endif
    a = '0; b = '0;
    a[A_W-1:0] = -14'sd8192; b[B_W-1:0] = -9'sd256;
    step(1'b1, a, b, 1'b1, acc, dlv, p);
    b[B_W-1:0] = 9'sd255;
    step(1'b1, a, b, 1'b1, acc, dlv, p);
    n = 0;
    for (int j = 0; j < 10 && n < 2; j++) begin
      step(1'b0, '0, '0, 1'b1, acc, dlv, p);
      if (dlv) begin
        q = sb.pop_front();
        checks++;
        if (p[OUT_W-1:0] !== want[n] || p[D_W-1:OUT_W] !== '0) begin
          failures++; $display("FAIL narrow_%0d got=%h want=%h", n, p, want[n]);
        end
        checks++; if (p !== q) begin failures++; $display("FAIL narrow_model_%0d got=%h want=%h", n, p, q); end
        n++;
      end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL narrow_count got=%0d want=2", n); end
  endtask

  task automatic test_backpressure();
    logic acc, dlv;
    logic [D_W-1:0] p, q;
    logic [AV_W-1:0] a;
    logic [BV_W-1:0] b;
    int nacc, ndlv;
    nacc = 0; ndlv = 0;
    for (int i = 0; i < 5; i++) begin
      for (int l = 0; l < LANES; l++) begin
        a[l*A_W +: A_W] = A_W'(10 * i + l);
        b[l*B_W +: B_W] = B_W'(i + 1);
      end
      step(1'b1, a, b, 1'b0, acc, dlv, p);
      if (acc) nacc++;
      if (i >= STAGES) begin
        checks++; if (acc !== 1'b0) begin failures++; $display("FAIL bp_ready_when_full cyc=%0d got=%b want=0", i, acc); end
        checks++; if (p !== sb[0] || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, p, sb[0]); end
      end
    end
    checks++; if (nacc != STAGES) begin failures++; $display("FAIL bp_held_count got=%0d want=%0d", nacc, STAGES); end
    // Full pipeline with downstream ready: accept and deliver in the same cycle
    a = '0; b = '0;
    a[A_W-1:0] = 14'sd77; b[B_W-1:0] = -9'sd5;
    step(1'b1, a, b, 1'b1, acc, dlv, p);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bp_accept_when_draining got=%b want=1", acc); end
    for (int j = 0; j < 10; j++) begin
      if (dlv) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_extra_beat got=%h want=none", p);
        end else begin
          q = sb.pop_front();
          if (p !== q) begin failures++; $display("FAIL bp_order beat=%0d got=%h want=%h", ndlv, p, q); end
        end
        ndlv++;
      end
      step(1'b0, '0, '0, 1'b1, acc, dlv, p);
    end
    checks++; if (ndlv != STAGES + 1) begin failures++; $display("FAIL bp_drain_count got=%0d want=%0d", ndlv, STAGES + 1); end
  endtask

  task automatic test_reset_midflight();
    logic acc, dlv;
    logic [D_W-1:0] p;
    logic [AV_W-1:0] a;
    logic [BV_W-1:0] b;
    int ndlv;
    a = '0; b = '0;
    a[A_W-1:0] = 14'sd123; b[B_W-1:0] = 9'sd45;
    step(1'b1, a, b, 1'b0, acc, dlv, p);
    step(1'b1, a, b, 1'b0, acc, dlv, p);
    step(1'b0, '0, '0, 1'b0, acc, dlv, p);
    step(1'b0, '0, '0, 1'b0, acc, dlv, p);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_prefill got=%b want=1", out_valid); end
    @(negedge clk);
    ap_rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    checks++; if (out_p !== '0) begin failures++; $display("FAIL mid_rst_p got=%h want=0", out_p); end
    sb.delete();
    @(negedge clk);
    ap_rst = 1'b0;
    ndlv = 0;
    for (int j = 0; j < 6; j++) begin
      step(1'b0, '0, '0, 1'b1, acc, dlv, p);
      if (dlv) ndlv++;
    end
    checks++; if (ndlv != 0) begin failures++; $display("FAIL mid_stale_beats got=%0d want=0", ndlv); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_random();
    logic acc, dlv, iv, ordy;
    logic [D_W-1:0] p, q;
    logic [AV_W-1:0] a;
    logic [BV_W-1:0] b;
    int nacc, cyc, sel;
    nacc = 0; cyc = 0;
    while ((nacc < 10000 || sb.size() != 0) && cyc < 60000) begin
      for (int l = 0; l < LANES; l++) begin
        sel = $urandom_range(0, 7);
        a[l*A_W +: A_W] = (sel == 0) ? {1'b1, {(A_W-1){1'b0}}} :
                          (sel == 1) ? {1'b0, {(A_W-1){1'b1}}} : A_W'($urandom);
        b[l*B_W +: B_W] = (sel == 0) ? {1'b1, {(B_W-1){1'b0}}} : B_W'($urandom);
      end
      iv   = (nacc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      ordy = 1'($urandom_range(0, 1));
      step(iv, a, b, ordy, acc, dlv, p);
      if (acc) nacc++;
      if (dlv) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rand_extra_beat cyc=%0d got=%h want=none", cyc, p);
        end else begin
          q = sb.pop_front();
          if (p !== q) begin failures++; $display("FAIL rand_beat cyc=%0d got=%h want=%h", cyc, p, q); end
        end
      end
      cyc++;
    end
    checks++;
    if (cyc >= 60000) begin
      failures++; $display("FAIL rand_timeout accepted=%0d pending=%0d want=10000/0", nacc, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_narrow();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
